// File: rtl/key_sweeper_pkg.sv
// Shared types and constants for the key sweeper and its key-check interface.
// Latency: n/a (types and constants only).
// Backpressure: n/a; the sweep paces itself at one key per clock.
package key_sweeper_pkg;

  localparam int KEY_W_DEF     = 32;
  localparam int CHECK_LAT_MAX = 8;
  localparam int CNT_W         = $clog2(CHECK_LAT_MAX);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SWEEP = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/key_sweeper_if.sv
// Control/result and key-check signals between the lab harness and key_sweeper.
// Latency: n/a (wires only).
// Backpressure: none; key_out/data_in run at a fixed check latency.
interface key_sweeper_if
  import key_sweeper_pkg::*;
#(
  parameter int KEY_W = KEY_W_DEF
) ();

  logic             start;
  logic [KEY_W-1:0] key_lo;
  logic [KEY_W-1:0] key_hi;
  logic [KEY_W-1:0] match_mask;
  logic [KEY_W-1:0] match_value;
  logic [KEY_W-1:0] key_out;
  logic [KEY_W-1:0] data_in;
  logic             busy;
  logic             done;
  logic             found;
  logic [KEY_W-1:0] found_key;

  // harness side: drives the sweep request and plays the device under check
  modport master (
    output start, key_lo, key_hi, match_mask, match_value, data_in,
    input  key_out, busy, done, found, found_key
  );

  // sweeper side
  modport slave (
    input  start, key_lo, key_hi, match_mask, match_value, data_in,
    output key_out, busy, done, found, found_key
  );

endinterface

// File: rtl/key_sweeper_delay.sv
// Shift line of {valid,key} pairing each issued key with its returning response.
// Latency: DEPTH clocks from in_* to out_*.
// Backpressure: none; flush drops every in-flight entry on the same edge.
module key_delay_line #(
  parameter int DEPTH = 1,
  parameter int KEY_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_vld,
  input  logic [KEY_W-1:0] in_key,
  output logic             out_vld,
  output logic [KEY_W-1:0] out_key
);

  logic [DEPTH-1:0] vld_q;
  logic [KEY_W-1:0] key_q [DEPTH];

  // shift one stage per clock; flush only kills the valid bits, stale keys are harmless
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
      for (int i = 0; i < DEPTH; i++) key_q[i] <= '0;
    end else if (flush) begin
      vld_q <= '0;
    end else begin
      vld_q[0] <= in_vld;
      key_q[0] <= in_key;
      for (int i = 1; i < DEPTH; i++) begin
        vld_q[i] <= vld_q[i-1];
        key_q[i] <= key_q[i-1];
      end
    end
  end

  assign out_vld = vld_q[DEPTH-1];
  assign out_key = key_q[DEPTH-1];

endmodule

// File: rtl/key_sweeper.sv
// Sweeps key_lo..key_hi onto key_out, one key per clock, and records the first key whose response matches.
// Latency: no match -> done (key_hi-key_lo+1)+CHECK_LAT+1 clocks after start; match -> CHECK_LAT clocks after it is seen.
// Backpressure: none; start is ignored while busy, and range/mask/value are latched only when start is accepted.
module key_sweeper
  import key_sweeper_pkg::*;
#(
  parameter int KEY_W     = KEY_W_DEF,
  parameter int CHECK_LAT = 1
) (
  input logic          clk,
  input logic          rst,
  key_sweeper_if.slave bus
);

  state_t           state;
  logic [KEY_W-1:0] key_q;
  logic             issue_q;     // key_q is a freshly issued candidate this cycle
  logic [KEY_W-1:0] hi_q;
  logic [KEY_W-1:0] mask_q;
  logic [KEY_W-1:0] value_q;
  logic [CNT_W-1:0] drain_cnt;
  logic             busy_q;
  logic             done_q;
  logic             found_q;
  logic [KEY_W-1:0] found_key_q;

  logic             head_vld;
  logic [KEY_W-1:0] head_key;
  logic             accept;
  logic             hit;

  assign accept = ((state == ST_IDLE) || (state == ST_DONE)) && bus.start;
  assign hit    = ((state == ST_SWEEP) || (state == ST_DRAIN)) && head_vld && !found_q &&
                  ((bus.data_in & mask_q) == (value_q & mask_q));

  key_delay_line #(
    .DEPTH (CHECK_LAT),
    .KEY_W (KEY_W)
  ) u_delay (
    .clk     (clk),
    .rst     (rst),
    .flush   (hit || accept),
    .in_vld  (issue_q),
    .in_key  (key_q),
    .out_vld (head_vld),
    .out_key (head_key)
  );

  // sweep FSM: issue keys, stop on first hit or after key_hi, then let the pipe drain
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      key_q       <= '0;
      issue_q     <= 1'b0;
      hi_q        <= '0;
      mask_q      <= '0;
      value_q     <= '0;
      drain_cnt   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      found_q     <= 1'b0;
      found_key_q <= '0;
    end else begin
      unique case (state)
        ST_IDLE, ST_DONE: begin
          if (bus.start) begin
            found_q     <= 1'b0;
            found_key_q <= '0;
            hi_q        <= bus.key_hi;
            mask_q      <= bus.match_mask;
            value_q     <= bus.match_value;
            if (bus.key_hi < bus.key_lo) begin
              // empty range: report an empty result without touching key_out
              state  <= ST_DONE;
              busy_q <= 1'b0;
              done_q <= 1'b1;
            end else begin
              state   <= ST_SWEEP;
              key_q   <= bus.key_lo;
              issue_q <= 1'b1;
              busy_q  <= 1'b1;
              done_q  <= 1'b0;
            end
          end
        end
        ST_SWEEP: begin
          if (hit) begin
            found_q     <= 1'b1;
            found_key_q <= head_key;
          end
          if (hit || !issue_q) begin
            // key_out holds its last value from here on
            state     <= ST_DRAIN;
            issue_q   <= 1'b0;
            drain_cnt <= CNT_W'(CHECK_LAT - 1);
          end else if (key_q == hi_q) begin
            // last key is on the bus; equality stop means key_hi=all-ones never wraps
            issue_q <= 1'b0;
          end else begin
            key_q <= key_q + KEY_W'(1);
          end
        end
        ST_DRAIN: begin
          if (hit) begin
            found_q     <= 1'b1;
            found_key_q <= head_key;
          end
          if (drain_cnt == '0) begin
            state  <= ST_DONE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt - CNT_W'(1);
          end
        end
      endcase
    end
  end

  assign bus.key_out   = key_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.found     = found_q;
  assign bus.found_key = found_key_q;

endmodule
